// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - request/result bundle between the issue controller and alu_seq
interface alu_seq_if #(
  parameter int W   = 8,
  parameter int Ops = 4
);
  logic           Start;
  logic [Ops-1:0] OP;
  logic [W-1:0]   InputA;
  logic [W-1:0]   InputB;
  logic [W-1:0]   Out;
  logic           Done;
  logic           Busy;
  logic           Cond;
  logic           Carry;
  logic           Zero;
  logic           Err;

  modport master (
    output Start, OP, InputA, InputB,
    input  Out, Done, Busy, Cond, Carry, Zero, Err
  );

  modport slave (
    input  Start, OP, InputA, InputB,
    output Out, Done, Busy, Cond, Carry, Zero, Err
  );
endinterface

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - clocked ALU with start/done handshake and iterative MUL/DIV
// Single-cycle ops complete on the accepting edge; MUL/DIV spend exactly W edges in RUN.
module alu_seq #(
  parameter int W   = 8,
  parameter int Ops = 4
) (
  input logic       Clk,
  input logic       Reset_n,
  alu_seq_if.slave  bus
);
  localparam int CW = $clog2(W) + 1;

  localparam logic [Ops-1:0] OP_ADD = Ops'(0);
  localparam logic [Ops-1:0] OP_SUB = Ops'(1);
  localparam logic [Ops-1:0] OP_AND = Ops'(2);
  localparam logic [Ops-1:0] OP_OR  = Ops'(3);
  localparam logic [Ops-1:0] OP_NOT = Ops'(4);
  localparam logic [Ops-1:0] OP_XOR = Ops'(5);
  localparam logic [Ops-1:0] OP_LSH = Ops'(6);
  localparam logic [Ops-1:0] OP_RSH = Ops'(7);
  localparam logic [Ops-1:0] OP_SLT = Ops'(8);
  localparam logic [Ops-1:0] OP_SEQ = Ops'(9);
  localparam logic [Ops-1:0] OP_MUL = Ops'(10);
  localparam logic [Ops-1:0] OP_DIV = Ops'(11);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic          is_div_q, is_div_n;
  logic [W-1:0]  a_q, a_n;
  logic [W-1:0]  b_q, b_n;
  logic [W:0]    acc_q, acc_n;

  logic [W-1:0]  out_q;
  logic          done_q, cond_q, carry_q, zero_q, err_q;

  logic          complete;
  logic [W-1:0]  res;
  logic          cond_n, carry_n, err_n;
  logic [W:0]    sum;
  logic [W:0]    rem_sh;
  logic          qbit;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q;
    is_div_n = is_div_q;
    a_n      = a_q;
    b_n      = b_q;
    acc_n    = acc_q;
    complete = 1'b0;
    res      = out_q;
    cond_n   = cond_q;
    carry_n  = carry_q;
    err_n    = 1'b0;
    sum      = '0;
    rem_sh   = '0;
    qbit     = 1'b0;

    case (state_q)
      RUN: begin
        // a_q doubles as dividend shifter and quotient accumulator for DIV
        if (is_div_q) begin
          rem_sh = {acc_q[W-1:0], a_q[W-1]};
          qbit   = (rem_sh >= {1'b0, b_q});
          acc_n  = qbit ? (rem_sh - {1'b0, b_q}) : rem_sh;
          a_n    = {a_q[W-2:0], qbit};
        end else begin
          acc_n  = b_q[0] ? (acc_q + {1'b0, a_q}) : acc_q;
          a_n    = a_q << 1;
          b_n    = b_q >> 1;
        end
        cnt_n = cnt_q + 1'b1;
        if (cnt_q == CW'(W - 1)) begin
          complete = 1'b1;
          res      = is_div_q ? a_n : acc_n[W-1:0];
          state_n  = DONE;
        end
      end

      default: begin
        state_n = IDLE;
        if (bus.Start) begin
          complete = 1'b1;
          state_n  = DONE;
          case (bus.OP)
            OP_ADD: begin
              sum     = {1'b0, bus.InputA} + {1'b0, bus.InputB};
              res     = sum[W-1:0];
              carry_n = sum[W];
            end
            OP_SUB: begin
              sum     = {1'b0, bus.InputA} + {1'b0, ~bus.InputB} + 1'b1;
              res     = sum[W-1:0];
              carry_n = sum[W];
            end
            OP_AND: res = bus.InputA & bus.InputB;
            OP_OR:  res = bus.InputA | bus.InputB;
            OP_NOT: res = ~bus.InputA;
            OP_XOR: res = bus.InputA ^ bus.InputB;
            // a shift amount of W or more already yields zero for a logical shift
            OP_LSH: res = bus.InputA << bus.InputB;
            OP_RSH: res = bus.InputA >> bus.InputB;
            OP_SLT: begin
              cond_n = (bus.InputA < bus.InputB);
              res    = {{(W-1){1'b0}}, cond_n};
            end
            OP_SEQ: begin
              cond_n = (bus.InputA == bus.InputB);
              res    = {{(W-1){1'b0}}, cond_n};
            end
            OP_MUL, OP_DIV: begin
              if (bus.OP == OP_DIV && bus.InputB == '0) begin
                res   = '1;
                err_n = 1'b1;
              end else begin
                complete = 1'b0;
                state_n  = RUN;
                a_n      = bus.InputA;
                b_n      = bus.InputB;
                acc_n    = '0;
                cnt_n    = '0;
                is_div_n = (bus.OP == OP_DIV);
              end
            end
            default: begin
              res   = '0;
              err_n = 1'b1;
            end
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      out_q    <= '0;
      done_q   <= 1'b0;
      cond_q   <= 1'b0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_n;
      is_div_q <= is_div_n;
      a_q      <= a_n;
      b_q      <= b_n;
      acc_q    <= acc_n;
      cond_q   <= cond_n;
      carry_q  <= carry_n;
      done_q   <= complete;
      err_q    <= complete & err_n;
      if (complete) begin
        out_q  <= res;
        zero_q <= (res == '0);
      end
    end
  end

  assign bus.Out   = out_q;
  assign bus.Done  = done_q;
  assign bus.Busy  = (state_q == RUN);
  assign bus.Cond  = cond_q;
  assign bus.Carry = carry_q;
  assign bus.Zero  = zero_q;
  assign bus.Err   = err_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - table-driven and sequence checks for alu_seq at W=8
module tb_alu_seq;
  localparam int W   = 8;
  localparam int OPS = 4;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Clk = ~Clk;

  alu_seq_if #(.W(W), .Ops(OPS)) bus ();
  alu_seq #(.W(W), .Ops(OPS)) dut (.Clk(Clk), .Reset_n(Reset_n), .bus(bus));

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] out;
    logic       carry;
    logic       cond;
    logic       zero;
    logic       err;
  } vec_t;

  vec_t vecs[18];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_out"},   32'(bus.Out),   0);
    chk({tag, "_done"},  32'(bus.Done),  0);
    chk({tag, "_busy"},  32'(bus.Busy),  0);
    chk({tag, "_cond"},  32'(bus.Cond),  0);
    chk({tag, "_carry"}, 32'(bus.Carry), 0);
    chk({tag, "_zero"},  32'(bus.Zero),  0);
    chk({tag, "_err"},   32'(bus.Err),   0);
  endtask

  // Issues a MUL/DIV, optionally fires an ADD mid-RUN, and watches 20 edges.
  task automatic run_long(input string tag, input logic [3:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] exp, input bit inject);
    int busy_n;
    int done_at;
    int dones;
    bus.OP = op; bus.InputA = a; bus.InputB = b; bus.Start = 1'b1;
    @(posedge Clk); #1;
    bus.Start = 1'b0;
    busy_n = 0; done_at = -1; dones = 0;
    if (bus.Busy) busy_n++;
    for (int e = 1; e <= 20; e++) begin
      if (inject && e == 3) begin
        bus.OP = 4'd0; bus.InputA = 8'd1; bus.InputB = 8'd1; bus.Start = 1'b1;
      end
      @(posedge Clk); #1;
      bus.Start = 1'b0;
      if (bus.Busy) busy_n++;
      if (bus.Done) begin
        dones++;
        if (done_at < 0) begin
          done_at = e;
          chk({tag, "_out"},  32'(bus.Out),  32'(exp));
          chk({tag, "_err"},  32'(bus.Err),  0);
          chk({tag, "_zero"}, 32'(bus.Zero), 32'(exp == 8'd0));
          chk({tag, "_busy_at_done"}, 32'(bus.Busy), 0);
        end
      end
    end
    chk({tag, "_busy_cycles"}, 32'(busy_n), 8);
    chk({tag, "_done_edge"},   32'(done_at), 8);
    chk({tag, "_done_pulses"}, 32'(dones), 1);
    chk({tag, "_out_held"},    32'(bus.Out), 32'(exp));
  endtask

  initial begin
    int dones;

    //            op     a      b      out    c  cnd z  err
    vecs[0]  = '{4'd0,  8'd200, 8'd100, 8'd44,  1, 0, 0, 0};
    vecs[1]  = '{4'd1,  8'd5,   8'd7,   8'd254, 0, 0, 0, 0};
    vecs[2]  = '{4'd1,  8'd7,   8'd7,   8'd0,   1, 0, 1, 0};
    vecs[3]  = '{4'd8,  8'd3,   8'd9,   8'd1,   1, 1, 0, 0};
    vecs[4]  = '{4'd0,  8'd1,   8'd1,   8'd2,   0, 1, 0, 0};
    vecs[5]  = '{4'd9,  8'd4,   8'd5,   8'd0,   0, 0, 1, 0};
    vecs[6]  = '{4'd9,  8'd6,   8'd6,   8'd1,   0, 1, 0, 0};
    vecs[7]  = '{4'd2,  8'hF0,  8'h3C,  8'h30,  0, 1, 0, 0};
    vecs[8]  = '{4'd3,  8'hF0,  8'h0F,  8'hFF,  0, 1, 0, 0};
    vecs[9]  = '{4'd4,  8'h5A,  8'h00,  8'hA5,  0, 1, 0, 0};
    vecs[10] = '{4'd5,  8'hFF,  8'hFF,  8'h00,  0, 1, 1, 0};
    vecs[11] = '{4'd6,  8'h81,  8'd1,   8'h02,  0, 1, 0, 0};
    vecs[12] = '{4'd7,  8'h81,  8'd8,   8'h00,  0, 1, 1, 0};
    vecs[13] = '{4'd7,  8'h80,  8'd7,   8'h01,  0, 1, 0, 0};
    vecs[14] = '{4'd6,  8'h01,  8'd7,   8'h80,  0, 1, 0, 0};
    vecs[15] = '{4'd13, 8'd5,   8'd5,   8'h00,  0, 1, 1, 1};
    vecs[16] = '{4'd11, 8'd9,   8'd0,   8'hFF,  0, 1, 0, 1};
    vecs[17] = '{4'd0,  8'd255, 8'd1,   8'h00,  1, 1, 1, 0};

    bus.Start = 1'b0; bus.OP = '0; bus.InputA = '0; bus.InputB = '0;
    repeat (2) @(posedge Clk);
    #1;
    chk_all_zero("reset");
    Reset_n = 1'b1;

    // back-to-back single-cycle issue: each Start lands while the previous op is in DONE
    for (int i = 0; i < 18; i++) begin
      bus.OP = vecs[i].op; bus.InputA = vecs[i].a; bus.InputB = vecs[i].b; bus.Start = 1'b1;
      @(posedge Clk); #1;
      chk($sformatf("v%0d_done", i),  32'(bus.Done),  1);
      chk($sformatf("v%0d_busy", i),  32'(bus.Busy),  0);
      chk($sformatf("v%0d_out", i),   32'(bus.Out),   32'(vecs[i].out));
      chk($sformatf("v%0d_carry", i), 32'(bus.Carry), 32'(vecs[i].carry));
      chk($sformatf("v%0d_cond", i),  32'(bus.Cond),  32'(vecs[i].cond));
      chk($sformatf("v%0d_zero", i),  32'(bus.Zero),  32'(vecs[i].zero));
      chk($sformatf("v%0d_err", i),   32'(bus.Err),   32'(vecs[i].err));
    end
    bus.Start = 1'b0;
    @(posedge Clk); #1;
    chk("idle_done", 32'(bus.Done), 0);
    chk("idle_err",  32'(bus.Err),  0);

    run_long("mul", 4'd10, 8'd20, 8'd20, 8'd144, 1'b0);
    chk("mul_cond_held",  32'(bus.Cond),  1);
    chk("mul_carry_held", 32'(bus.Carry), 1);
    run_long("mul_inj", 4'd10, 8'd20, 8'd20, 8'd144, 1'b1);
    run_long("div", 4'd11, 8'd200, 8'd7, 8'd28, 1'b0);
    run_long("mul_wrap", 4'd10, 8'd255, 8'd255, 8'd1, 1'b0);
    run_long("div_small", 4'd11, 8'd5, 8'd9, 8'd0, 1'b0);

    // reset during RUN cycle 3 of a MUL
    run_long("div_pre", 4'd11, 8'd255, 8'd2, 8'd127, 1'b0);
    bus.OP = 4'd10; bus.InputA = 8'd20; bus.InputB = 8'd20; bus.Start = 1'b1;
    @(posedge Clk); #1;
    bus.Start = 1'b0;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    chk("rst_busy_before", 32'(bus.Busy), 1);
    chk("rst_cond_before", 32'(bus.Cond), 1);
    Reset_n = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    dones = 0;
    for (int e = 0; e < 3; e++) begin
      @(posedge Clk); #1;
      if (bus.Done) dones++;
    end
    chk("rst_no_done", 32'(dones), 0);
    chk("rst_busy_held", 32'(bus.Busy), 0);
    Reset_n = 1'b1;
    bus.OP = 4'd0; bus.InputA = 8'd1; bus.InputB = 8'd2; bus.Start = 1'b1;
    @(posedge Clk); #1;
    bus.Start = 1'b0;
    chk("post_rst_done", 32'(bus.Done), 1);
    chk("post_rst_out",  32'(bus.Out),  3);
    chk("post_rst_busy", 32'(bus.Busy), 0);
    @(posedge Clk); #1;
    chk("post_rst_done_drop", 32'(bus.Done), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, clocked successor to the single-cycle datapath ALU. It adds a start/done handshake, registered results and status flags, and iterative multi-cycle unsigned multiply and divide. It sits between the register file read ports and the writeback mux; the controller stalls instruction issue while `Busy` is high.

## Interface
- `W`, default 8: data width. Legal values are 4 to 32.
- `Ops`, default 4: opcode width.
- `Clk`  in  1  rising-edge clock.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `Start`  in  1  request; captures `OP`, `InputA` and `InputB` when accepted.
- `OP`  in  Ops  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 NOT, 5 XOR, 6 LSH, 7 RSH, 8 SLT, 9 SEQ, 10 MUL, 11 DIV. Values 12 to 15 are illegal.
- `InputA`, `InputB`  in  W  operands, unsigned.
- `Out`  out  W  registered result; holds until the next completion.
- `Done`  out  1  one-cycle pulse; `Out` and the flags are valid in the same cycle.
- `Busy`  out  1  high while a MUL or DIV is iterating.
- `Cond`  out  1  sticky compare flag.
- `Carry`  out  1  carry-out from ADD, or not-borrow from SUB.
- `Zero`  out  1  high when the completed result equals 0.
- `Err`  out  1  illegal opcode or divide by zero.

## Operation
- There are three states: IDLE, RUN and DONE. `Busy` is high only in RUN.
- `Start` is accepted in IDLE or DONE. `Start` during RUN is ignored: nothing is captured and nothing is queued.
- Single-cycle ops (0 to 9, and 12 to 15): on the accepting edge, compute and register `Out` and the flags, then go to DONE.
  - ADD: A+B, mod 2^W. `Carry` is bit W of the sum.
  - SUB: A+~B+1. `Carry` is 1 when A ≥ B.
  - AND, OR and XOR are bitwise. NOT gives ~A and ignores B.
  - LSH and RSH are logical shifts. A shift amount B ≥ W gives 0.
  - SLT and SEQ: `Out` = 1 or 0, and `Cond` is loaded with the same bit.
- MUL and DIV: the accepting edge loads the operands into internal registers and enters RUN with the iteration counter at 0.
  - MUL uses shift-and-add, one multiplier bit per edge. `Out` is the low W bits of A×B.
  - DIV uses restoring division, one quotient bit per edge. `Out` = floor(A/B); the remainder is discarded.
  - Exactly W edges are spent in RUN. The W-th RUN edge writes `Out` and the flags and moves to DONE.
- Divide by zero: DIV with B=0 does not enter RUN. It completes as a single-cycle op with `Out` all ones and `Err`=1.
- Illegal opcodes complete as a single-cycle op with `Out`=0 and `Err`=1.
- DONE lasts one cycle. It goes to IDLE, or straight to the new operation if `Start` is high (back-to-back issue is allowed).
- Flag update rules:
  - `Zero`, `Err` and `Done` are updated on every completion. `Done` and `Err` are 0 at all other times.
  - `Carry` is updated only by ADD and SUB, and holds otherwise.
  - `Cond` is updated only by SLT and SEQ, and holds otherwise, including across MUL, DIV and illegal ops.
- Reset (`Reset_n`=0) takes effect immediately and aborts any operation. State goes to IDLE. `Out`, `Done`, `Busy`, `Cond`, `Carry`, `Zero`, `Err` and the internal counter and operand registers all go to 0.

## Timing
- Single-cycle op with `Start` sampled at edge k: `Done`=1 and `Out` valid from edge k until edge k+1.
- MUL or DIV with `Start` at edge k:
  - `Busy`=1 from edge k until edge k+W.
  - `Done`=1 from edge k+W until edge k+W+1.
  - Latency is W cycles; for W=8, 8 cycles.
- Sustained throughput: one single-cycle op per clock; one MUL or DIV per W+1 clocks when the next `Start` arrives in DONE.
- The inputs are sampled only on the accepting edge. They may change freely during RUN.
- Reset release is synchronised by the integrator. The first `Start` is honoured on the first rising edge with `Reset_n`=1.

## Test plan
All scenarios use W=8.
- **ADD with carry:** ADD 200+100 -> `Out`=44, `Carry`=1, `Zero`=0, `Done` one cycle after `Start`. SUB 5-7 -> `Out`=254, `Carry`=0.
- **Sticky Cond:** SLT 3,9 -> `Out`=1, `Cond`=1. A following ADD 1+1 leaves `Cond`=1. SEQ 4,5 -> `Cond`=0.
- **MUL latency and busy:**
  - MUL 20×20 -> `Out`=144, `Busy` high for exactly 8 cycles, `Done` on the 8th edge after `Start`.
  - A `Start` with ADD issued mid-RUN is ignored: exactly one `Done` pulse appears.
- **DIV and divide by zero:** DIV 200/7 -> `Out`=28 after 8 cycles. DIV 9/0 -> `Out`=255, `Err`=1, `Done` after 1 cycle, `Busy` never high.
- **Shifts and illegal op:** LSH 0x81 by 1 -> 0x02. RSH by 8 -> 0. OP=13 -> `Out`=0, `Err`=1, `Cond` unchanged.
- **Reset mid-operation:** assert `Reset_n`=0 on RUN cycle 3 of a MUL -> all outputs 0 immediately, no `Done`. After release, an ADD 1+2 returns 3.
